// File: rtl/conv_layer_sched_pkg.sv
// Shared descriptor layout and FSM encoding for the multi-layer convolution scheduler.
package conv_layer_sched_pkg;

    localparam int TENSOR_SIZE      = 8;
    localparam int KERNEL_SIZE      = 4;
    localparam int CHANNELS_SIZE    = 8;
    localparam int STRIDE_SIZE      = 4;
    localparam int KERNEL_NUMS_SIZE = 8;

    localparam int LAYER_DESC_W = TENSOR_SIZE + KERNEL_SIZE + CHANNELS_SIZE
                                + STRIDE_SIZE + KERNEL_NUMS_SIZE;

    // Descriptor fields packed from the LSB up.
    localparam int KERNEL_NUMS_LSB = 0;
    localparam int STRIDE_LSB      = KERNEL_NUMS_LSB + KERNEL_NUMS_SIZE;
    localparam int CHANNELS_LSB    = STRIDE_LSB + STRIDE_SIZE;
    localparam int KERNEL_SIZE_LSB = CHANNELS_LSB + CHANNELS_SIZE;
    localparam int TENSOR_LSB      = KERNEL_SIZE_LSB + KERNEL_SIZE;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    function automatic logic [LAYER_DESC_W-1:0] pack_desc(
        input logic [TENSOR_SIZE-1:0]      tensor,
        input logic [KERNEL_SIZE-1:0]      kernel,
        input logic [CHANNELS_SIZE-1:0]    channels,
        input logic [STRIDE_SIZE-1:0]      stride,
        input logic [KERNEL_NUMS_SIZE-1:0] kernel_nums
    );
        return {tensor, kernel, channels, stride, kernel_nums};
    endfunction

endpackage

// File: rtl/layer_desc_ram.sv
// Layer descriptor register file: synchronous write and clear, combinational read.
module layer_desc_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv_layer_sched.sv
// Sequences the conv engine through a table of layer descriptors: load config,
// let it settle, pulse start, wait for write-done, repeat.
module conv_layer_sched
    import conv_layer_sched_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int SETTLE     = 2,
    parameter int TIMEOUT    = 1 << 20
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_we_i,
    input  logic [$clog2(MAX_LAYERS)-1:0] cfg_addr_i,
    input  logic [LAYER_DESC_W-1:0]       cfg_wdata_i,
    input  logic                          run_i,
    input  logic [$clog2(MAX_LAYERS):0]   num_layers_i,
    input  logic                          abort_i,
    output logic [TENSOR_SIZE-1:0]        tensor_size_o,
    output logic [KERNEL_SIZE-1:0]        kernel_size_o,
    output logic [CHANNELS_SIZE-1:0]      channels_o,
    output logic [STRIDE_SIZE-1:0]        stride_o,
    output logic [KERNEL_NUMS_SIZE-1:0]   kernel_nums_o,
    output logic                          gemm_start_o,
    input  logic                          gemm_w_done_i,
    output logic [$clog2(MAX_LAYERS)-1:0] layer_idx_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int AW = $clog2(MAX_LAYERS);
    localparam int NW = AW + 1;
    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t                  state_q, state_d;
    logic [AW-1:0]           layer_idx_q, layer_idx_d;
    logic [NW-1:0]           nl_q, nl_d;
    logic [SW-1:0]           scnt_q, scnt_d;
    logic [WW-1:0]           wcnt_q, wcnt_d;
    logic [LAYER_DESC_W-1:0] cfg_q, cfg_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    ram_we;
    logic [LAYER_DESC_W-1:0] ram_rdata;

    layer_desc_ram #(
        .DEPTH (MAX_LAYERS),
        .WIDTH (LAYER_DESC_W)
    ) u_desc_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (ram_we),
        .waddr_i (cfg_addr_i),
        .wdata_i (cfg_wdata_i),
        .raddr_i (layer_idx_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        layer_idx_d = layer_idx_q;
        nl_d        = nl_q;
        scnt_d      = scnt_q;
        wcnt_d      = wcnt_q;
        cfg_d       = cfg_q;
        err_d       = err_q;
        ram_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                ram_we = cfg_we_i;
                if (run_i) begin
                    err_d = 1'b0;
                    if (num_layers_i == '0) begin
                        state_d = S_FIN;
                    end else begin
                        nl_d        = (num_layers_i > NW'(MAX_LAYERS)) ? NW'(MAX_LAYERS) : num_layers_i;
                        layer_idx_d = '0;
                        state_d     = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                cfg_d   = ram_rdata;
                scnt_d  = SW'(SETTLE - 1);
                state_d = S_SETUP;
            end
            S_SETUP: begin
                if (scnt_q == '0) begin
                    state_d = S_START;
                end else begin
                    scnt_d = scnt_q - SW'(1);
                end
            end
            S_START: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Write-done beats a simultaneous timeout.
                if (gemm_w_done_i) begin
                    if ((NW'(layer_idx_q) + NW'(1)) < nl_q) begin
                        layer_idx_d = layer_idx_q + AW'(1);
                        state_d     = S_LOAD;
                    end else begin
                        state_d = S_FIN;
                    end
                end else if ((TIMEOUT != 0) && (wcnt_q == WW'(TIMEOUT - 1))) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort freezes everything visible and just drops back to IDLE.
        if (abort_i) begin
            state_d     = S_IDLE;
            layer_idx_d = layer_idx_q;
            nl_d        = nl_q;
            cfg_d       = cfg_q;
            err_d       = err_q;
        end

        done_d  = (state_d == S_FIN);
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            layer_idx_q <= '0;
            nl_q        <= '0;
            scnt_q      <= '0;
            wcnt_q      <= '0;
            cfg_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_idx_q <= layer_idx_d;
            nl_q        <= nl_d;
            scnt_q      <= scnt_d;
            wcnt_q      <= wcnt_d;
            cfg_q       <= cfg_d;
            err_q       <= err_d;
            done_q      <= done_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    assign tensor_size_o = cfg_q[TENSOR_LSB +: TENSOR_SIZE];
    assign kernel_size_o = cfg_q[KERNEL_SIZE_LSB +: KERNEL_SIZE];
    assign channels_o    = cfg_q[CHANNELS_LSB +: CHANNELS_SIZE];
    assign stride_o      = cfg_q[STRIDE_LSB +: STRIDE_SIZE];
    assign kernel_nums_o = cfg_q[KERNEL_NUMS_LSB +: KERNEL_NUMS_SIZE];
    assign gemm_start_o  = start_q;
    assign layer_idx_o   = layer_idx_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: dut_a uses default timing, dut_b a 16-cycle timeout.
`timescale 1ns/1ps
module tb_conv_layer_sched;
    import conv_layer_sched_pkg::*;

    localparam int AW = 3;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst, cfg_we, run_a, run_b, abort, w_done_a, w_done_b;
    logic [AW-1:0]           cfg_addr;
    logic [LAYER_DESC_W-1:0] cfg_wdata;
    logic [NW-1:0]           num_layers;

    logic [TENSOR_SIZE-1:0]      a_tensor, b_tensor;
    logic [KERNEL_SIZE-1:0]      a_kernel, b_kernel;
    logic [CHANNELS_SIZE-1:0]    a_chan, b_chan;
    logic [STRIDE_SIZE-1:0]      a_stride, b_stride;
    logic [KERNEL_NUMS_SIZE-1:0] a_knum, b_knum;
    logic                        a_start, a_busy, a_done, a_err;
    logic                        b_start, b_busy, b_done, b_err;
    logic [AW-1:0]               a_idx, b_idx;
    logic [LAYER_DESC_W-1:0]     cfg_a, cfg_b;

    assign cfg_a = {a_tensor, a_kernel, a_chan, a_stride, a_knum};
    assign cfg_b = {b_tensor, b_kernel, b_chan, b_stride, b_knum};

    always #5 clk = ~clk;

    conv_layer_sched dut_a (
        .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .run_i(run_a), .num_layers_i(num_layers), .abort_i(abort),
        .tensor_size_o(a_tensor), .kernel_size_o(a_kernel), .channels_o(a_chan),
        .stride_o(a_stride), .kernel_nums_o(a_knum), .gemm_start_o(a_start),
        .gemm_w_done_i(w_done_a), .layer_idx_o(a_idx), .busy_o(a_busy),
        .done_o(a_done), .err_o(a_err)
    );

    conv_layer_sched #(.TIMEOUT(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .run_i(run_b), .num_layers_i(num_layers), .abort_i(abort),
        .tensor_size_o(b_tensor), .kernel_size_o(b_kernel), .channels_o(b_chan),
        .stride_o(b_stride), .kernel_nums_o(b_knum), .gemm_start_o(b_start),
        .gemm_w_done_i(w_done_b), .layer_idx_o(b_idx), .busy_o(b_busy),
        .done_o(b_done), .err_o(b_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_done  = 0;
    int s0, d0;
    logic [LAYER_DESC_W-1:0] descs [8];
    logic [LAYER_DESC_W-1:0] d_a, d_b, d_c, d_g, d_n;

    always @(posedge clk) begin
        if (a_start) n_start <= n_start + 1;
        if (a_done)  n_done  <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [LAYER_DESC_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    // Engine model for dut_a: answer each start with write-done lat cycles later.
    task automatic serve(input int n, input int lat);
        for (int k = 0; k < n; k++) begin
            int b;
            b = 0;
            while (a_start !== 1'b1 && b < 200) begin
                step();
                b++;
            end
            check("start_seen", 32'(b < 200), 32'd1);
            check("start_idx", 32'(a_idx), k);
            check("start_cfg", cfg_a, descs[k]);
            repeat (lat) step();
            check("wait_cfg", cfg_a, descs[k]);
            check("wait_idx", 32'(a_idx), k);
            w_done_a = 1'b1;
            step();
            w_done_a = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(a_busy), 0);
        check({tag, "_done"}, 32'(a_done), 0);
        check({tag, "_start"}, 32'(a_start), 0);
        check({tag, "_err"}, 32'(a_err), 0);
        check({tag, "_idx"}, 32'(a_idx), 0);
        check({tag, "_cfg"}, cfg_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; run_a = 1'b0; run_b = 1'b0; abort = 1'b0;
        w_done_a = 1'b0; w_done_b = 1'b0; cfg_addr = '0; cfg_wdata = '0; num_layers = '0;
        d_a = pack_desc(8'd8, 4'd3, 8'd2, 4'd1, 8'd4);
        d_b = pack_desc(8'd16, 4'd5, 8'd3, 4'd2, 8'd8);
        d_c = pack_desc(8'd32, 4'd1, 8'd64, 4'd1, 8'd16);
        d_g = pack_desc(8'd255, 4'd15, 8'd255, 4'd15, 8'd255);
        d_n = pack_desc(8'd12, 4'd3, 8'd6, 4'd1, 8'd2);
        for (int i = 0; i < 8; i++) descs[i] = '0;

        step();
        check_zero("rst");
        check("rst_b_err", 32'(b_err), 0);
        step();
        rst = 1'b0;

        // Single layer, exact timing.
        wr(3'd0, d_a);
        descs[0] = d_a;
        run_a = 1'b1; num_layers = 4'd1;
        step();                                  // t+1
        run_a = 1'b0;
        s0 = n_start;
        check("t1_busy_t1", 32'(a_busy), 1);
        check("t1_cfg_t1", cfg_a, 0);
        step();                                  // t+2
        check("t1_cfg_t2", cfg_a, d_a);
        check("t1_nostart_t2", 32'(a_start), 0);
        step(); step();                          // t+4
        check("t1_start_t4", 32'(a_start), 1);
        repeat (46) step();                      // t+50
        check("t1_one_start", n_start - s0, 1);
        check("t1_busy_t50", 32'(a_busy), 1);
        w_done_a = 1'b1;
        step();                                  // t+51
        w_done_a = 1'b0;
        check("t1_done_t51", 32'(a_done), 1);
        step();                                  // t+52
        check("t1_busy_t52", 32'(a_busy), 0);
        check("t1_done_t52", 32'(a_done), 0);
        check("t1_cfg_held", cfg_a, d_a);

        // Three layers, engine answers 20 cycles after each start.
        wr(3'd1, d_b); wr(3'd2, d_c);
        descs[1] = d_b; descs[2] = d_c;
        s0 = n_start; d0 = n_done;
        run_a = 1'b1; num_layers = 4'd3;
        step();
        run_a = 1'b0;
        serve(3, 20);
        check("t3_done", 32'(a_done), 1);
        step();
        check("t3_idle", 32'(a_busy), 0);
        check("t3_starts", n_start - s0, 3);
        check("t3_dones", n_done - d0, 1);
        check("t3_last_idx", 32'(a_idx), 2);

        // Zero layers: straight to FIN, no start.
        s0 = n_start;
        run_a = 1'b1; num_layers = 4'd0;
        step();
        run_a = 1'b0;
        check("t0_done", 32'(a_done), 1);
        check("t0_err", 32'(a_err), 0);
        step();
        check("t0_idle", 32'(a_busy), 0);
        check("t0_nostart", n_start - s0, 0);

        // Abort in SETUP of layer 1, then stray write-done in IDLE.
        s0 = n_start; d0 = n_done;
        run_a = 1'b1; num_layers = 4'd3;
        step();
        run_a = 1'b0;
        serve(1, 5);                             // now in LOAD of layer 1
        step();                                  // SETUP
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_busy", 32'(a_busy), 0);
        check("ab_done", 32'(a_done), 0);
        check("ab_idx", 32'(a_idx), 1);
        check("ab_cfg", cfg_a, d_b);
        w_done_a = 1'b1;
        repeat (3) step();
        w_done_a = 1'b0;
        step();
        check("ab_starts", n_start - s0, 1);
        check("ab_dones", n_done - d0, 0);
        check("ab_still_idle", 32'(a_busy), 0);

        // Table writes while busy are dropped.
        run_a = 1'b1; num_layers = 4'd1;
        step();
        run_a = 1'b0;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = d_g;
        serve(1, 3);
        cfg_we = 1'b0;
        step();
        run_a = 1'b1; num_layers = 4'd1;
        step();
        run_a = 1'b0;
        serve(1, 3);
        step();

        // Write and run in the same cycle: LOAD sees the new descriptor.
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = d_n;
        run_a = 1'b1; num_layers = 4'd1;
        step();
        cfg_we = 1'b0; run_a = 1'b0;
        descs[0] = d_n;
        serve(1, 2);
        step();

        // num_layers above MAX_LAYERS clamps to 8.
        s0 = n_start;
        run_a = 1'b1; num_layers = 4'd15;
        step();
        run_a = 1'b0;
        serve(8, 2);
        check("cl_done", 32'(a_done), 1);
        step();
        check("cl_starts", n_start - s0, 8);

        // dut_b: timeout 16 cycles after WAIT entry (t+5).
        run_b = 1'b1; num_layers = 4'd1;
        step();                                  // t+1
        run_b = 1'b0;
        repeat (19) step();                      // t+20
        check("to_err_t20", 32'(b_err), 0);
        check("to_done_t20", 32'(b_done), 0);
        check("to_busy_t20", 32'(b_busy), 1);
        step();                                  // t+21
        check("to_err_t21", 32'(b_err), 1);
        check("to_done_t21", 32'(b_done), 1);
        step();
        check("to_idle", 32'(b_busy), 0);
        check("to_err_sticky", 32'(b_err), 1);

        // Next run clears err; write-done on the timeout cycle wins.
        run_b = 1'b1; num_layers = 4'd1;
        step();                                  // u+1
        run_b = 1'b0;
        check("to_err_cleared", 32'(b_err), 0);
        repeat (19) step();                      // u+20
        w_done_b = 1'b1;
        step();                                  // u+21
        w_done_b = 1'b0;
        check("race_done", 32'(b_done), 1);
        check("race_err", 32'(b_err), 0);
        step();
        check("race_idle", 32'(b_busy), 0);

        // Reset in WAIT of layer 1 clears outputs and the table.
        run_a = 1'b1; num_layers = 4'd2;
        step();
        run_a = 1'b0;
        serve(1, 2);                             // LOAD of layer 1
        repeat (4) step();                       // WAIT of layer 1
        check("rw_pre_idx", 32'(a_idx), 1);
        check("rw_pre_busy", 32'(a_busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("rw");
        for (int i = 0; i < 8; i++) descs[i] = '0;
        run_a = 1'b1; num_layers = 4'd1;
        step();
        run_a = 1'b0;
        serve(1, 2);
        step();
        check("rw_final_idle", 32'(a_busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
